// File: rtl/waveform_renderer.sv
// Waveform pixel source for the VGA timing generator.
// A fetch FSM copies 640 decimated audio samples into a column RAM during
// vertical blanking; a two-stage pixel path turns (row,col) into a colour.
module waveform_renderer #(
  parameter int         ADDR_W     = 16,
  parameter int         DECIM      = 64,
  parameter int         TIMEOUT    = 15,
  parameter logic [7:0] WAVE_COLOR = 8'hFC,
  parameter logic [7:0] AXIS_COLOR = 8'h1C,
  parameter logic [7:0] BG_COLOR   = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vsync,
  input  logic [8:0]        pix_row,
  input  logic [9:0]        pix_col,
  input  logic              pix_req,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [ADDR_W-1:0] sample_addr,
  output logic              sample_rd,
  input  logic [7:0]        sample_data,
  input  logic              sample_valid,
  output logic [7:0]        rgb_out,
  output logic              frame_loaded
);

  localparam int NCOL  = 640;
  localparam int TMO_W = $clog2(TIMEOUT + 2);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);
  localparam logic [9:0]       LAST_COL = 10'd639;
  localparam logic [7:0]       SILENCE  = 8'd128;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_STORE, S_DONE} state_e;

  state_e            state_q;
  logic              vsync_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] sample_addr_q;
  logic [9:0]        col_q;
  logic [TMO_W-1:0]  tmo_q;
  logic              sample_rd_q;
  logic              frame_loaded_q;
  logic              col_valid_q;

  // pix_req only marks the latch point; the colour is settled well before it.
  logic unused_pix_req;
  assign unused_pix_req = pix_req;

  logic              vsync_fall;
  logic              tmo_hit;
  logic              ram_we;
  logic [7:0]        ram_wdata;
  logic [ADDR_W-1:0] col_addr;

  assign vsync_fall = vsync_q & ~vsync;
  assign tmo_hit    = (tmo_q == TMO_MAX);
  // An abort in the same cycle wins over a pending store.
  assign ram_we     = (state_q == S_WAIT) && !vsync_fall && (sample_valid || tmo_hit);
  // Real data wins over a simultaneous timeout.
  assign ram_wdata  = sample_valid ? sample_data : SILENCE;
  // Product wraps modulo 2^ADDR_W, as does the sum with the base address.
  assign col_addr   = base_q + ADDR_W'(32'(col_q) * 32'(DECIM));

  // Fetch FSM: one sample per column, restarted by every vsync falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      vsync_q        <= 1'b1;
      base_q         <= '0;
      sample_addr_q  <= '0;
      col_q          <= '0;
      tmo_q          <= '0;
      sample_rd_q    <= 1'b0;
      frame_loaded_q <= 1'b0;
      col_valid_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      vsync_q        <= vsync;
      frame_loaded_q <= 1'b0;
      if (vsync_fall) begin
        base_q      <= base_addr;
        col_q       <= '0;
        sample_rd_q <= 1'b0;
        state_q     <= S_REQ;
      end else begin
        case (state_q)
          S_IDLE: state_q <= S_IDLE;
          S_REQ: begin
            sample_addr_q <= col_addr;
            sample_rd_q   <= 1'b1;
            tmo_q         <= '0;
            state_q       <= S_WAIT;
          end
          S_WAIT: begin
            if (sample_valid || tmo_hit) begin
              sample_rd_q <= 1'b0;
              state_q     <= S_STORE;
            end else begin
              tmo_q <= tmo_q + 1'b1;
            end
          end
          S_STORE: begin
            if (col_q == LAST_COL) begin
              state_q <= S_DONE;
            end else begin
              col_q   <= col_q + 10'd1;
              state_q <= S_REQ;
            end
          end
          S_DONE: begin
            frame_loaded_q <= 1'b1;
            col_valid_q    <= 1'b1;
            state_q        <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign sample_addr  = sample_addr_q;
  assign sample_rd    = sample_rd_q;
  assign frame_loaded = frame_loaded_q;

  logic [7:0] ram [NCOL];
  logic [7:0] ram_rd_q;
  logic [9:0] rd_idx;

  assign rd_idx = (pix_col < 10'd640) ? pix_col : 10'd0;

  // Column RAM: FSM write port, pixel-path read port (read returns old data).
  // NOTE: RAM has no reset; col_valid_q masks its stale contents instead.
  always_ff @(posedge clk) begin
    if (ram_we) ram[col_q] <= ram_wdata;
    ram_rd_q <= ram[rd_idx];
  end

  logic [8:0] row_q;
  logic       oor_q;

  // Pixel stage 1: carry the row and the out-of-range flag alongside the RAM read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q <= '0;
      oor_q <= 1'b1;
    end else begin
      row_q <= pix_row;
      oor_q <= (pix_row >= 9'd480) || (pix_col >= 10'd640);
    end
  end

  logic [7:0] s;
  logic [9:0] y;
  logic [9:0] row_w;
  logic       in_wave;

  // Waveform span: rows between y = 368 - s and the centre line, inclusive.
  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latch).
    s       = col_valid_q ? ram_rd_q : SILENCE;
    y       = 10'd368 - {2'b00, s};
    row_w   = {1'b0, row_q};
    in_wave = 1'b0;
    if (y <= 10'd240) in_wave = (row_w >= y) && (row_w <= 10'd240);
    else              in_wave = (row_w >= 10'd240) && (row_w <= y);
  end

  logic [7:0] rgb_q;

  // Pixel stage 2: registered colour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  rgb_q <= 8'h00;
    else if (oor_q)           rgb_q <= 8'h00;
    else if (in_wave)         rgb_q <= WAVE_COLOR;
    else if (row_q == 9'd240) rgb_q <= AXIS_COLOR;
    else                      rgb_q <= BG_COLOR;
  end

  assign rgb_out = rgb_q;

endmodule

// File: tb/tb_waveform_renderer.sv
// Bench for waveform_renderer: random sample memory with a latency-programmable
// responder, a column-level reference model, and directed frame scenarios.
module tb_waveform_renderer;

  localparam int         ADDR_W = 16;
  localparam int         DECIM  = 64;
  localparam int         TIMEOUT = 15;
  localparam int         NCOL   = 640;
  localparam logic [7:0] WAVE   = 8'hFC;
  localparam logic [7:0] AXIS   = 8'h1C;
  localparam logic [7:0] BG     = 8'h00;
  localparam int         FRAME_BUDGET = 2 * NCOL * (TIMEOUT + 4) + 200;

  logic              clk = 1'b0;
  logic              rst;
  logic              vsync;
  logic [8:0]        pix_row;
  logic [9:0]        pix_col;
  logic              pix_req;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] sample_addr;
  logic              sample_rd;
  logic [7:0]        sample_data = 8'h00;
  logic              sample_valid = 1'b0;
  logic [7:0]        rgb_out;
  logic              frame_loaded;

  always #5 clk = ~clk;

  waveform_renderer #(
    .ADDR_W(ADDR_W), .DECIM(DECIM), .TIMEOUT(TIMEOUT),
    .WAVE_COLOR(WAVE), .AXIS_COLOR(AXIS), .BG_COLOR(BG)
  ) dut (
    .clk(clk), .rst(rst), .vsync(vsync),
    .pix_row(pix_row), .pix_col(pix_col), .pix_req(pix_req),
    .base_addr(base_addr), .sample_addr(sample_addr), .sample_rd(sample_rd),
    .sample_data(sample_data), .sample_valid(sample_valid),
    .rgb_out(rgb_out), .frame_loaded(frame_loaded)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0]  mem [65536];
  int          exp_col [NCOL];
  bit          exp_valid = 1'b0;
  logic [15:0] addr_q [$];
  logic        rd_prev = 1'b0;
  bit          resp_never = 1'b0;
  int          resp_lat = 2;
  int          rd_cnt = 0;

  // Sample memory: data arrives resp_lat cycles into a read; in "never" mode it
  // only ever raises valid while no read is pending (must be ignored).
  always @(negedge clk) begin
    if (resp_never) begin
      sample_valid = !sample_rd;
      sample_data  = 8'h00;
      rd_cnt       = 0;
    end else if (sample_rd) begin
      rd_cnt = rd_cnt + 1;
      if (rd_cnt == resp_lat) begin
        sample_valid = 1'b1;
        sample_data  = mem[sample_addr];
      end else begin
        sample_valid = 1'b0;
        sample_data  = 8'($urandom);
      end
    end else begin
      rd_cnt       = 0;
      sample_valid = 1'b0;
    end
  end

  // Record the address of every new read request.
  always @(negedge clk) begin
    if (sample_rd && !rd_prev) addr_q.push_back(sample_addr);
    rd_prev = sample_rd;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference colour from the drawing rule, using the stored column sample.
  function automatic logic [7:0] exp_pixel(input int row, input int col);
    int s, y, lo, hi;
    if (row >= 480 || col >= NCOL) return 8'h00;
    s  = exp_valid ? exp_col[col] : 128;
    y  = 240 - (s - 128);
    lo = (y < 240) ? y : 240;
    hi = (y > 240) ? y : 240;
    if (row >= lo && row <= hi) return WAVE;
    if (row == 240) return AXIS;
    return BG;
  endfunction

  task automatic pix_check(input string tag, input int row, input int col);
    @(negedge clk);
    pix_row = 9'(row);
    pix_col = 10'(col);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check($sformatf("%s r%0d c%0d", tag, row, col), 32'(rgb_out), 32'(exp_pixel(row, col)));
  endtask

  task automatic rand_pixels(input int n);
    int r, c, s;
    for (int i = 0; i < n; i++) begin
      if (i % 4 == 3) begin
        r = int'($urandom_range(0, 511));
        c = int'($urandom_range(0, 1023));
      end else begin
        c = int'($urandom_range(0, NCOL - 1));
        s = exp_valid ? exp_col[c] : 128;
        r = 240 - (s - 128) + int'($urandom_range(0, 2)) - 1;
      end
      pix_check("rand_pix", r, c);
    end
  endtask

  task automatic fill_mem(input bit constant, input logic [7:0] val);
    for (int a = 0; a < 65536; a++) mem[a] = constant ? val : 8'($urandom);
  endtask

  // Runs one fetch frame (optionally aborted after abort_at requests) and
  // checks completion, the pulse, and the full request address sequence.
  task automatic run_frame(input logic [15:0] b0, input int abort_at, input logic [15:0] b1,
                           input bit never, input int lat, output int cycles, output int start);
    logic [15:0] b;
    int cnt, vs_low, lim, bad_k;
    bit done, aborted;
    resp_never = never;
    resp_lat   = lat;
    b          = b0;
    done       = 1'b0;
    aborted    = 1'b0;
    @(negedge clk);
    base_addr = b0;
    #1 vsync  = 1'b0;
    vs_low    = 0;
    start     = addr_q.size();
    @(posedge clk);
    cnt = 0;
    while (!done && cnt < FRAME_BUDGET) begin
      @(negedge clk);
      #1;
      if (frame_loaded) begin
        done = 1'b1;
      end else begin
        if (!vsync) begin
          vs_low++;
          if (vs_low >= 3) vsync = 1'b1;
        end else if (abort_at >= 0 && !aborted && (addr_q.size() - start) > abort_at) begin
          aborted   = 1'b1;
          b         = b1;
          base_addr = b1;
          vsync     = 1'b0;
          vs_low    = 0;
          start     = addr_q.size();
        end
        @(posedge clk);
        cnt++;
      end
    end
    vsync  = 1'b1;
    cycles = cnt;
    check("frame_done", 32'(done), 32'd1);
    @(negedge clk);
    #1;
    check("loaded_pulse", 32'(frame_loaded), 32'd0);
    check("fetch_count", 32'(addr_q.size() - start), 32'(NCOL));
    lim   = (addr_q.size() - start < NCOL) ? addr_q.size() - start : NCOL;
    bad_k = lim - 1;
    for (int k = 0; k < lim; k++) begin
      if (addr_q[start + k] !== 16'(b + k * DECIM)) begin
        bad_k = k;
        break;
      end
    end
    if (bad_k >= 0)
      check($sformatf("addr_seq col%0d", bad_k), 32'(addr_q[start + bad_k]), 32'(16'(b + bad_k * DECIM)));
    exp_valid = 1'b1;
    for (int c = 0; c < NCOL; c++) exp_col[c] = never ? 128 : int'(mem[16'(b + c * DECIM)]);
  endtask

  initial begin
    int cyc, st, s0, cnt, vs_low;
    logic [15:0] b;
    rst = 1'b1; vsync = 1'b1; pix_row = '0; pix_col = '0; pix_req = 1'b0; base_addr = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_rgb", 32'(rgb_out), 32'd0);
    check("rst_rd", 32'(sample_rd), 32'd0);
    check("rst_addr", 32'(sample_addr), 32'd0);
    check("rst_loaded", 32'(frame_loaded), 32'd0);
    rst = 1'b0;

    // No frame loaded yet: flat line
    pix_check("flat0", 240, 17);
    pix_check("flat0", 239, 17);
    pix_check("flat0", 241, 17);

    // Constant 200 with two-cycle latency
    fill_mem(1'b1, 8'd200);
    run_frame(16'($urandom), -1, 16'h0, 1'b0, 2, cyc, st);
    pix_check("s200", 168, 10);
    pix_check("s200", 240, 10);
    pix_check("s200", 167, 10);
    pix_check("s200", 241, 10);
    pix_check("s200", 300, 10);
    rand_pixels(6);

    // Extreme samples and address wrap from base 0xFFF0
    fill_mem(1'b0, 8'h00);
    mem[16'hFFF0 + 16'd320] = 8'd0;
    mem[16'hFFF0 + 16'd384] = 8'd255;
    run_frame(16'hFFF0, -1, 16'h0, 1'b0, int'($urandom_range(1, 4)), cyc, st);
    check("wrap_col1", 32'(addr_q[st + 1]), 32'h0030);
    pix_check("s0", 239, 5);
    pix_check("s0", 240, 5);
    pix_check("s0", 368, 5);
    pix_check("s0", 369, 5);
    pix_check("s255", 112, 6);
    pix_check("s255", 113, 6);
    pix_check("s255", 240, 6);
    pix_check("s255", 241, 6);
    pix_check("oor_col", 240, 700);
    pix_check("oor_row", 500, 5);
    rand_pixels(8);

    // Memory never answers; valid raised only while no read is pending
    run_frame(16'($urandom), -1, 16'h0, 1'b1, 0, cyc, st);
    n_cmp++;
    assert (cyc >= NCOL * (TIMEOUT + 3) && cyc <= NCOL * (TIMEOUT + 3) + 2) else begin
      n_fail++;
      $error("FAIL timeout_cycles observed=%0d expected=%0d..%0d", cyc,
             NCOL * (TIMEOUT + 3), NCOL * (TIMEOUT + 3) + 2);
    end
    resp_never = 1'b0;
    pix_check("tmo_flat", 240, 333);
    pix_check("tmo_flat", 239, 333);
    rand_pixels(4);

    // Second vsync edge after 100 columns restarts at the new base
    fill_mem(1'b0, 8'h00);
    b = 16'($urandom);
    run_frame(16'($urandom), 100, b, 1'b0, int'($urandom_range(1, 3)), cyc, st);
    check("abort_restart", 32'(addr_q[st]), 32'(b));
    rand_pixels(10);

    // Reset in the middle of WAIT at column 300
    resp_never = 1'b0;
    resp_lat   = 12;
    @(negedge clk);
    base_addr = 16'($urandom);
    #1 vsync  = 1'b0;
    s0 = addr_q.size(); cnt = 0; vs_low = 0;
    while ((addr_q.size() - s0) < 301 && cnt < FRAME_BUDGET) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      if (!vsync) begin
        vs_low++;
        if (vs_low >= 3) vsync = 1'b1;
      end
      cnt++;
    end
    vsync = 1'b1;
    check("reach_col300", 32'(addr_q.size() - s0), 32'd301);
    check("rd_held", 32'(sample_rd), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("mid_rst_rd", 32'(sample_rd), 32'd0);
    check("mid_rst_rgb", 32'(rgb_out), 32'd0);
    check("mid_rst_loaded", 32'(frame_loaded), 32'd0);
    check("mid_rst_addr", 32'(sample_addr), 32'd0);
    rst = 1'b0;
    exp_valid = 1'b0;
    s0 = addr_q.size();
    repeat (50) @(negedge clk);
    #1;
    check("idle_after_rst", 32'(addr_q.size() - s0), 32'd0);
    pix_check("post_rst", 240, 300);
    pix_check("post_rst", 239, 300);
    pix_check("post_rst", 241, 300);
    rand_pixels(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
